// File: rtl/set_cond_pipe.sv
// Two-stage pipelined set-on-condition unit: SEQ/SNE/SLT/SGT/SLE/SGE on signed or
// unsigned WIDTH-bit operands. Produces {WIDTH-1 zeros, cond} with valid/ready on both sides.
module set_cond_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_unsigned,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_set,
   output logic             out_illegal
);

   typedef enum logic [2:0] {
      OP_SEQ = 3'b000,
      OP_SNE = 3'b001,
      OP_SLT = 3'b010,
      OP_SGT = 3'b011,
      OP_SLE = 3'b100,
      OP_SGE = 3'b101
   } op_e;

   // Stage 1 registers
   logic             s1_valid;
   logic [2:0]       s1_op;
   logic             s1_unsigned;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;

   // Stage 2 valid (out_set / out_illegal are the stage 2 data registers)
   logic             s2_valid;

   logic             s1_adv;
   logic             s2_adv;
   logic             s1_move;

   logic [WIDTH:0]   ext_a;
   logic [WIDTH:0]   ext_b;
   logic [WIDTH:0]   diff;
   logic             lt;
   logic             eq;
   logic             cond;
   logic             illegal;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign s1_move   = s1_valid && s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   // One extra bit keeps the subtract from overflowing, so the top bit is the true sign.
   always_comb begin
      ext_a = {(s1_unsigned ? 1'b0 : s1_a[WIDTH-1]), s1_a};
      ext_b = {(s1_unsigned ? 1'b0 : s1_b[WIDTH-1]), s1_b};
      diff  = ext_a - ext_b;
      lt    = diff[WIDTH];
      eq    = (s1_a == s1_b);
   end

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      cond    = 1'b0;
      illegal = 1'b0;
      case (s1_op)
         OP_SEQ:  cond = eq;
         OP_SNE:  cond = !eq;
         OP_SLT:  cond = lt;
         OP_SGT:  cond = !lt && !eq;
         OP_SLE:  cond = lt || eq;
         OP_SGE:  cond = !lt;
         default: illegal = 1'b1;
      endcase
   end

   // NOTE: operand registers are qualified by s1_valid, so they need no reset; only control and outputs clear.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         s1_op       <= in_op;
         s1_unsigned <= in_unsigned;
         s1_a        <= in_a;
         s1_b        <= in_b;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s2_valid    <= 1'b0;
         out_set     <= '0;
         out_illegal <= 1'b0;
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (s2_adv) s2_valid <= s1_valid;
         if (s1_move) begin
            out_set     <= {{(WIDTH-1){1'b0}}, cond};
            out_illegal <= illegal;
         end
      end
   end

endmodule

// File: tb/tb_set_cond_pipe.sv
// Self-checking bench for set_cond_pipe: directed cases, random stream against a
// queue-based reference model, stall/reset scenarios, and an exhaustive WIDTH=2 sweep.
module tb_set_cond_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic        in_unsigned;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_set;
   logic        out_illegal;

   logic        in_valid2;
   logic        in_ready2;
   logic [2:0]  in_op2;
   logic        in_unsigned2;
   logic [1:0]  in_a2;
   logic [1:0]  in_b2;
   logic        out_valid2;
   logic        out_ready2;
   logic [1:0]  out_set2;
   logic        out_illegal2;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] set;
      logic        ill;
      int          edges;
   } item_t;

   item_t exp_q[$];
   item_t q2[$];

   logic        hold_prev;
   logic [31:0] hold_set;
   logic        hold_ill;

   set_cond_pipe #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_unsigned(in_unsigned), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_set(out_set), .out_illegal(out_illegal)
   );

   set_cond_pipe #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_op(in_op2),
      .in_unsigned(in_unsigned2), .in_a(in_a2), .in_b(in_b2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .out_set(out_set2), .out_illegal(out_illegal2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: interpret the low n bits as integers and compare them directly.
   function automatic logic ref_cond(input int n, input logic [2:0] op, input logic uns,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic ill);
      longint va;
      longint vb;
      va  = longint'(a);
      vb  = longint'(b);
      ill = 1'b0;
      if (!uns && a[n-1]) va = va - (longint'(1) << n);
      if (!uns && b[n-1]) vb = vb - (longint'(1) << n);
      case (op)
         3'd0:    return va == vb;
         3'd1:    return va != vb;
         3'd2:    return va <  vb;
         3'd3:    return va >  vb;
         3'd4:    return va <= vb;
         3'd5:    return va >= vb;
         default: begin ill = 1'b1; return 1'b0; end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'hFFFF_FFFF;
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // One clock cycle of the 32-bit DUT; called at posedge+1, returns at next posedge+1.
   task automatic cycle(input logic iv, input logic [2:0] op, input logic uns,
                        input logic [31:0] a, input logic [31:0] b, input logic ordy);
      logic  exp_valid;
      logic  exp_ready;
      logic  acc;
      logic  drn;
      logic  ill;
      item_t it;
      in_valid    = iv;
      in_op       = op;
      in_unsigned = uns;
      in_a        = a;
      in_b        = b;
      out_ready   = ordy;
      #1;
      // Head item sits in the output stage once it has seen two edges; two items means both stages full.
      exp_valid = (exp_q.size() > 0) && (exp_q[0].edges >= 2);
      exp_ready = !((exp_q.size() == 2) && !ordy);
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      if (exp_valid) begin
         check("out_set", 64'(out_set), 64'(exp_q[0].set));
         check("out_illegal", 64'(out_illegal), 64'(exp_q[0].ill));
      end
      if (hold_prev) begin
         check("hold_set", 64'(out_set), 64'(hold_set));
         check("hold_ill", 64'(out_illegal), 64'(hold_ill));
      end
      hold_prev = exp_valid && !ordy;
      hold_set  = out_set;
      hold_ill  = out_illegal;
      acc = iv && exp_ready;
      drn = exp_valid && ordy;
      it.set   = 32'(ref_cond(32, op, uns, a, b, ill));
      it.ill   = ill;
      it.edges = 1;
      @(posedge clk);
      if (drn) void'(exp_q.pop_front());
      foreach (exp_q[i]) exp_q[i].edges++;
      if (acc) exp_q.push_back(it);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1);
   endtask

   // Directly compare the presented result with a hand-derived constant.
   task automatic direct(input string tag, input logic [31:0] exp_set, input logic exp_ill);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_set"}, 64'(out_set), 64'(exp_set));
      check({tag, "_ill"}, 64'(out_illegal), 64'(exp_ill));
   endtask

   task automatic one(input string tag, input logic [2:0] op, input logic uns,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_set, input logic exp_ill);
      cycle(1'b1, op, uns, a, b, 1'b1);
      cycle(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      direct(tag, exp_set, exp_ill);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      hold_prev = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_set", 64'(out_set), 64'd0);
      check("rst_out_illegal", 64'(out_illegal), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic ill2;
      logic c2;
      item_t it2;
      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_unsigned = 1'b0;
      in_a = '0; in_b = '0; out_ready = 1'b1; hold_prev = 1'b0;
      in_valid2 = 1'b0; in_op2 = '0; in_unsigned2 = 1'b0;
      in_a2 = '0; in_b2 = '0; out_ready2 = 1'b1;
      @(posedge clk);
      do_reset();

      // Directed sign/extreme cases
      one("slt_s_neg1_1",  3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
      one("slt_u_neg1_1",  3'b010, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      one("sgt_s_max_min", 3'b011, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 1'b0);
      one("sgt_u_max_min", 3'b011, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      one("slt_s_min_max", 3'b010, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0);
      one("slt_u_min_max", 3'b010, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0);
      one("sle_5_5",       3'b100, 1'b0, 32'd5, 32'd5, 32'd1, 1'b0);
      one("sge_5_5",       3'b101, 1'b0, 32'd5, 32'd5, 32'd1, 1'b0);
      one("sne_5_5",       3'b001, 1'b1, 32'd5, 32'd5, 32'd0, 1'b0);
      one("illegal_110",   3'b110, 1'b0, 32'd7, 32'd7, 32'd0, 1'b1);
      one("seq_after_ill", 3'b000, 1'b0, 32'd9, 32'd9, 32'd1, 1'b0);
      drain();

      // Back-to-back stream with out_ready held high
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 3'($urandom_range(0, 5)), 1'($urandom), pick(), pick(), 1'b1);
      drain();

      // Stream with a 5-cycle downstream stall in the middle
      for (int i = 0; i < 16; i++)
         cycle(1'b1, 3'($urandom_range(0, 5)), 1'($urandom), pick(), pick(),
               !(i >= 3 && i < 8));
      drain();

      // Random traffic with random backpressure, illegal ops included
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ra;
         ra = pick();
         cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
               ra, ($urandom_range(0, 3) == 0) ? ra : pick(), 1'($urandom_range(0, 3) != 0));
      end
      drain();

      // Reset with both stages full, then a fresh op
      cycle(1'b1, 3'b000, 1'b0, 32'd1, 32'd1, 1'b0);
      cycle(1'b1, 3'b000, 1'b0, 32'd2, 32'd2, 1'b0);
      cycle(1'b1, 3'b001, 1'b0, 32'd2, 32'd3, 1'b0);
      do_reset();
      one("after_reset", 3'b011, 1'b0, 32'd10, 32'd3, 32'd1, 1'b0);
      drain();

      // Exhaustive WIDTH=2 sweep streamed at full rate
      for (int i = 0; i < 260; i++) begin
         logic [7:0] v;
         v = 8'(i);
         in_valid2    = (i < 256);
         in_op2       = v[7:5];
         in_unsigned2 = v[4];
         in_a2        = v[3:2];
         in_b2        = v[1:0];
         #1;
         check("w2_in_ready", 64'(in_ready2), 64'd1);
         c2 = ref_cond(2, v[7:5], v[4], 32'(v[3:2]), 32'(v[1:0]), ill2);
         @(posedge clk);
         if (i < 256) begin
            it2.set   = 32'(c2);
            it2.ill   = ill2;
            it2.edges = 0;
            q2.push_back(it2);
         end
         #1;
         if (out_valid2) begin
            if (q2.size() == 0) begin
               check("w2_spurious", 64'd1, 64'd0);
            end else begin
               check("w2_result", {61'd0, out_illegal2, out_set2},
                     {61'd0, q2[0].ill, 1'b0, q2[0].set[0]});
               void'(q2.pop_front());
            end
         end
      end
      in_valid2 = 1'b0;
      check("w2_all_drained", 64'(q2.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
